// File: rtl/axi_read_pkg.sv
// Shared types for the AXI4-Lite read pipeline: response codes and FSM states.
package axi_read_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/axi_addr_fifo.sv
// Read-address queue: power-of-two ring buffer with an explicit occupancy counter.
// An entry pushed into an empty queue becomes visible only on the following cycle.
module axi_addr_fifo
    import axi_read_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        din,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_read_pipe.sv
// AXI4-Lite read front end: queues AR addresses and serialises them onto a single-beat backend.
// Define AXI_READ_TIMEOUT_EN to bound the backend wait to TIMEOUT cycles with an SLVERR response.
module axi_read_pipe
    import axi_read_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0000_1000),
    parameter int                TIMEOUT    = 16
) (
    input  logic              axi_clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [ADDR_W-1:0] addr_out,
    output logic              read_req,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_ready
);

    localparam int ALIGN_W = $clog2(DATA_W / 8);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              addr_ok;
    logic              ready_en;
    logic              wait_expired;
    logic              full_unused;

    // ready_en keeps ARREADY low through reset and raises it on the first edge afterwards.
    assign ARREADY     = ready_en && (count < CNT_W'(DEPTH));
    assign push        = ARVALID && ARREADY;
    assign pop         = (state == S_IDLE) && !empty;
    assign addr_ok     = (head < ADDR_LIMIT) && (head[ALIGN_W-1:0] == '0);
    assign full_unused = full;

    axi_addr_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (axi_clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (ARADDR),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

`ifdef AXI_READ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] timer;

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((state == S_WAIT) && !data_ready) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    assign wait_expired = (state == S_WAIT) && !data_ready && (timer == TMR_W'(TIMEOUT - 1));
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign wait_expired   = 1'b0;
`endif

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!empty) state_next = addr_ok ? S_ISSUE : S_RESP;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (data_ready || wait_expired) state_next = S_RESP;
            S_RESP:  if (RREADY) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Response registers load only on state transitions, so they stay frozen while RESP stalls.
    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
            read_req <= 1'b0;
            addr_out <= '0;
        end else begin
            read_req <= pop && addr_ok;
            if (pop && addr_ok) begin
                addr_out <= head;
            end
            case (state)
                S_IDLE: begin
                    if (pop && !addr_ok) begin
                        RVALID <= 1'b1;
                        RDATA  <= '0;
                        RRESP  <= RESP_SLVERR;
                    end
                end
                S_WAIT: begin
                    if (data_ready) begin
                        RVALID <= 1'b1;
                        RDATA  <= data_in;
                        RRESP  <= RESP_OKAY;
                    end else if (wait_expired) begin
                        RVALID <= 1'b1;
                        RDATA  <= '0;
                        RRESP  <= RESP_SLVERR;
                    end
                end
                S_RESP: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_pipe.sv
// Bench for axi_read_pipe: table-driven single reads, directed corner cases and a randomized
// run against a transaction-level scoreboard. Honours AXI_READ_TIMEOUT_EN for the timeout case.
module tb_axi_read_pipe;

    logic        axi_clk = 1'b0;
    logic        rst_n;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] addr_out;
    logic        read_req;
    logic [31:0] data_in;
    logic        data_ready;

    axi_read_pipe dut (
        .axi_clk    (axi_clk),
        .rst_n      (rst_n),
        .ARADDR     (ARADDR),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .addr_out   (addr_out),
        .read_req   (read_req),
        .data_in    (data_in),
        .data_ready (data_ready)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [31:0] addr;
        bit          ok;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          reqs;
        int          rv_at;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    txn_t        exp_q[$];
    bit          model_on, be_en, be_rand, be_fixed_en, be_busy, spur_en, spur_force;
    int          be_delay, be_wait;
    logic [31:0] be_data, be_fixed, last_req_addr, prev_rdata;
    logic [1:0]  prev_rresp;
    bit          prev_hold, prev_req;

    function automatic bit addr_ok(logic [31:0] a);
        return (a < 32'h1000) && (a % 4 == 0);
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One clock: scoreboard the current cycle, drive the backend, then advance past the edge.
    task automatic step();
        txn_t t;
        if (prev_hold) begin
            check_output("hold_rvalid", RVALID, 1);
            check_output("hold_rdata", RDATA, prev_rdata);
            check_output("hold_rresp", RRESP, prev_rresp);
        end
        prev_hold  = RVALID && !RREADY;
        prev_rdata = RDATA;
        prev_rresp = RRESP;
        if (read_req) begin
            check_output("req_single_cycle", prev_req, 0);
            last_req_addr = addr_out;
            if (model_on) begin
                check_output("req_has_txn", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check_output("req_addr", addr_out, exp_q[0].addr);
                    check_output("req_legal", exp_q[0].ok, 1);
                end
            end
        end else begin
            check_output("addr_out_hold", addr_out, last_req_addr);
        end
        prev_req = read_req;
        if (model_on && RVALID && RREADY) begin
            check_output("resp_has_txn", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                check_output("resp_code", RRESP, t.ok ? 2'b00 : 2'b10);
                check_output("resp_data", RDATA, t.ok ? t.data : 32'h0);
            end
        end
        if (model_on && ARVALID && ARREADY) begin
            exp_q.push_back('{ARADDR, addr_ok(ARADDR), 32'h0});
        end
        data_ready = 1'b0;
        data_in    = $urandom;
        if (read_req) begin
            be_busy = be_en;
            be_wait = be_rand ? int'($urandom_range(0, 3)) : be_delay;
            be_data = be_fixed_en ? be_fixed : $urandom;
        end else if (be_busy) begin
            if (be_wait == 0) begin
                data_ready = 1'b1;
                data_in    = be_data;
                be_busy    = 1'b0;
                if (model_on && exp_q.size() != 0) begin
                    t        = exp_q[0];
                    t.data   = be_data;
                    exp_q[0] = t;
                end
            end else begin
                be_wait--;
            end
        end else begin
            data_ready = spur_force || (spur_en && $urandom_range(0, 3) == 0);
        end
        @(posedge axi_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        data_ready = 1'b0;
        spur_force = 1'b0;
        #1;
        check_output("rst_arready", ARREADY, 0);
        check_output("rst_rvalid", RVALID, 0);
        check_output("rst_rdata", RDATA, 0);
        check_output("rst_rresp", RRESP, 0);
        check_output("rst_read_req", read_req, 0);
        check_output("rst_addr_out", addr_out, 0);
        exp_q.delete();
        be_busy       = 1'b0;
        prev_hold     = 1'b0;
        prev_req      = 1'b0;
        last_req_addr = '0;
        repeat (2) @(posedge axi_clk);
        #1;
        rst_n = 1'b1;
        check_output("arready_before_edge", ARREADY, 0);
        @(posedge axi_clk);
        #1;
        check_output("arready_after_edge", ARREADY, 1);
    endtask

    // Cycle 0 is the AR handshake cycle; reports when read_req and RVALID were first seen.
    task automatic run_single(input logic [31:0] addr, input int limit, output int req_cnt,
                              output int req_at, output logic [31:0] req_addr, output int rv_at,
                              output logic [1:0] resp, output logic [31:0] rdata);
        int c;
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b0;
        c = 0;
        while (!ARREADY && c < 50) begin
            step();
            c++;
        end
        step();
        ARVALID  = 1'b0;
        req_cnt  = 0;
        req_at   = -1;
        req_addr = '0;
        rv_at    = -1;
        resp     = 2'b11;
        rdata    = 32'hFFFF_FFFF;
        for (int i = 1; i < limit && rv_at < 0; i++) begin
            if (read_req) begin
                req_cnt++;
                req_at   = i;
                req_addr = addr_out;
            end
            if (RVALID) begin
                rv_at  = i;
                resp   = RRESP;
                rdata  = RDATA;
                RREADY = 1'b1;
            end
            step();
        end
        RREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (read_req) req_cnt++;
            step();
        end
    endtask

    task automatic drain();
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || RVALID); i++) step();
        check_output("drain_empty", exp_q.size(), 0);
        RREADY = 1'b0;
        repeat (3) step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            3:       return {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
            4:       return 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[8];
        logic [31:0] b2b[6];
        logic [31:0] req_addr, rdata, cur;
        logic [1:0]  resp;
        int          reqs, req_at, rv_at, acc;
        bit          pend, saw_rvalid, saw_req;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1, 5};
        vecs[1] = '{32'h0000_1000, 32'h1111_1111, 2'b10, 32'h0,         0, 2};
        vecs[2] = '{32'h0000_0006, 32'h2222_2222, 2'b10, 32'h0,         0, 2};
        vecs[3] = '{32'h0000_0FFC, 32'h1234_5678, 2'b00, 32'h1234_5678, 1, 5};
        vecs[4] = '{32'h0000_0000, 32'hA5A5_5A5A, 2'b00, 32'hA5A5_5A5A, 1, 5};
        vecs[5] = '{32'h0000_0FFF, 32'h3333_3333, 2'b10, 32'h0,         0, 2};
        vecs[6] = '{32'h0000_1004, 32'h4444_4444, 2'b10, 32'h0,         0, 2};
        vecs[7] = '{32'hFFFF_FFF0, 32'h5555_5555, 2'b10, 32'h0,         0, 2};
        b2b = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

        ARADDR = '0; data_in = '0; data_ready = 1'b0; RREADY = 1'b0; ARVALID = 1'b0;
        model_on = 1'b1; be_en = 1'b1; be_rand = 1'b0; be_delay = 1; be_fixed_en = 1'b1;
        be_fixed = '0; spur_en = 1'b0;
        do_reset();

        $display("[TB] single-read table");
        for (int v = 0; v < 8; v++) begin
            be_fixed = vecs[v].data;
            run_single(vecs[v].addr, 60, reqs, req_at, req_addr, rv_at, resp, rdata);
            check_output($sformatf("vec%0d_resp", v), resp, vecs[v].resp);
            check_output($sformatf("vec%0d_rdata", v), rdata, vecs[v].rdata);
            check_output($sformatf("vec%0d_reqs", v), reqs, vecs[v].reqs);
            check_output($sformatf("vec%0d_rvalid_cycle", v), rv_at, vecs[v].rv_at);
            if (vecs[v].reqs == 1) begin
                check_output($sformatf("vec%0d_req_cycle", v), req_at, 2);
                check_output($sformatf("vec%0d_req_addr", v), req_addr, vecs[v].addr);
            end
        end

        $display("[TB] backpressure");
        be_fixed = 32'hCAFE_F00D;
        ARADDR = 32'h20; ARVALID = 1'b1; RREADY = 1'b0;
        step();
        ARVALID = 1'b0;
        for (int i = 0; i < 20 && !RVALID; i++) step();
        for (int i = 0; i < 10; i++) begin
            spur_force = (i == 3);
            check_output("bp_rvalid", RVALID, 1);
            check_output("bp_rdata", RDATA, 32'hCAFE_F00D);
            check_output("bp_rresp", RRESP, 0);
            step();
        end
        spur_force = 1'b0;
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check_output("bp_rvalid_drop", RVALID, 0);
        drain();

        $display("[TB] back-to-back");
        be_fixed_en = 1'b0;
        RREADY = 1'b0; ARVALID = 1'b1; acc = 0;
        for (int i = 0; i < 30 && acc < 5; i++) begin
            ARADDR = b2b[acc];
            if (ARREADY) acc++;
            step();
        end
        ARADDR = b2b[5];
        for (int i = 0; i < 6; i++) begin
            check_output("b2b_arready_full", ARREADY, 0);
            step();
        end
        RREADY = 1'b1;
        for (int i = 0; i < 30 && acc < 6; i++) begin
            if (ARREADY) acc++;
            step();
        end
        ARVALID = 1'b0;
        check_output("b2b_accepted", acc, 6);
        drain();

        $display("[TB] randomized traffic");
        be_rand = 1'b1; spur_en = 1'b1; pend = 1'b0; cur = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                cur  = rand_addr();
            end
            ARVALID = pend;
            ARADDR  = pend ? cur : $urandom;
            RREADY  = ($urandom_range(0, 3) != 0);
            if (pend && ARREADY) pend = 1'b0;
            step();
        end
        spur_en = 1'b0;
        drain();
        be_rand = 1'b0;

        $display("[TB] backend timeout");
        model_on = 1'b0; be_en = 1'b0;
        run_single(32'h80, 120, reqs, req_at, req_addr, rv_at, resp, rdata);
        check_output("to_reqs", reqs, 1);
`ifdef AXI_READ_TIMEOUT_EN
        check_output("to_rvalid_cycle", rv_at, 19);
        check_output("to_resp", resp, 2'b10);
        check_output("to_rdata", rdata, 0);
`else
        check_output("to_no_rvalid", rv_at < 0, 1);
`endif
        do_reset();

        $display("[TB] reset while waiting");
        RREADY = 1'b0; ARVALID = 1'b1;
        ARADDR = 32'h40; step();
        ARADDR = 32'h44; step();
        ARADDR = 32'h48;
        check_output("rw_req_issued", read_req, 1);
        step();
        ARVALID = 1'b0;
        do_reset();
        spur_force = 1'b1;
        step();
        spur_force = 1'b0;
        RREADY = 1'b1; saw_rvalid = 1'b0; saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw_rvalid |= RVALID;
            saw_req    |= read_req;
            step();
        end
        check_output("rw_no_rvalid", saw_rvalid, 0);
        check_output("rw_no_read_req", saw_req, 0);
        check_output("rw_arready", ARREADY, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
